multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; state and opcode encodings SHALL come from the shared package.
REQ-002 clk  in  1  single system clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 opcode  in  6  IR[31:26], valid from the ID state onward.
REQ-005 mem_ready  in  1  memory completion handshake, used only when MEM_READY_EN is defined.
REQ-006 PCWrite, PCWriteCond  out  1 each  PC update enables to the PC register.
REQ-007 PCSource  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-008 IorD, MemRead, MemWrite, IRWrite  out  1 each  memory address select (0 = PC, 1 = ALUOut) and memory/IR enables.
REQ-009 RegDst, MemtoReg, RegWrite  out  1 each  register-file controls.
REQ-010 ALUSrcA  out  1 (0 = PC, 1 = reg A); ALUSrcB  out  2 (00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2); ALUOp  out  2 (00 = add, 01 = sub, 10 = funct, 11 = add-imm).
REQ-011 illegal_op  out  1  one-cycle pulse on an undecoded opcode.
REQ-012 state  out  4  current state code, for debug.

Function
REQ-013 Controller SHALL be a Moore FSM; every output except illegal_op SHALL decode from the registered state only.
REQ-014 States SHALL be: RST, IF, ID, MADDR, MRD, MWB, MWR, REXE, RWB, IEXE, IWB, BEQ, JMP.
REQ-015 Transitions: RST->IF; IF->ID; ID->MADDR (lw 100011, sw 101011) | REXE (000000) | IEXE (addi 001000) | BEQ (000100) | JMP (000010) | IF (other opcode).
REQ-016 Transitions: MADDR->MRD (lw) | MWR (sw); MRD->MWB; MWB, MWR, RWB, IWB, BEQ, JMP->IF; REXE->RWB; IEXE->IWB.
REQ-017 Per-instruction cycle counts without wait states SHALL be: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
REQ-018 IF outputs: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=00.
REQ-019 ID outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precomputed into ALUOut).
REQ-020 MADDR outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00. MRD outputs: MemRead=1, IorD=1. MWR outputs: MemWrite=1, IorD=1. MWB outputs: RegWrite=1, MemtoReg=1, RegDst=0.
REQ-021 REXE outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10. RWB outputs: RegWrite=1, RegDst=1, MemtoReg=0.
REQ-022 IEXE outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=11. IWB outputs: RegWrite=1, RegDst=0, MemtoReg=0.
REQ-023 BEQ outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. JMP outputs: PCWrite=1, PCSource=10.
REQ-024 Any output not listed for a state SHALL be 0.
REQ-025 illegal_op SHALL be registered, high exactly the cycle after ID decoded an unknown opcode (coincident with return to IF).
REQ-026 PCWrite and PCWriteCond SHALL never both be 1 in one state; MemRead and MemWrite SHALL never both be 1.

Reset
REQ-027 rst low SHALL force state=RST and illegal_op=0 asynchronously; all outputs SHALL be 0 in RST.
REQ-028 Reset asserted mid-instruction SHALL abandon it with no further write enables; first IF SHALL occur one clock after rst deasserts.

Configuration
REQ-029 With MEM_READY_EN defined, IF, MRD and MWR SHALL hold their state and outputs until mem_ready=1, exiting on that edge; IF SHALL assert PCWrite and IRWrite only in its final cycle (mem_ready=1).
REQ-030 Without MEM_READY_EN, mem_ready SHALL be ignored and every state SHALL last exactly one cycle.

Structure
REQ-031 Shared package SHALL hold state encodings, opcode constants, and the ALUOp/ALUSrcB/PCSource encodings.
REQ-032 No sub-module; next-state logic and output decode SHALL live in this module.

Verification
REQ-033 Reset release, opcode=100011 held -> states RST, IF, ID, MADDR, MRD, MWB, IF; RegWrite=1 and MemtoReg=1 only in MWB.
REQ-034 opcode=000100 -> IF, ID, BEQ, IF; PCWriteCond=1 and PCSource=01 only in BEQ; PCWrite=0 in BEQ.
REQ-035 opcode=111111 -> IF, ID, IF; illegal_op=1 for exactly one cycle; no RegWrite or MemWrite.
REQ-036 MEM_READY_EN defined, opcode=101011, mem_ready low 3 cycles in MWR -> MemWrite=1 for 4 cycles, then IF.
REQ-037 rst pulsed low during REXE of opcode=000000 -> all outputs 0 immediately; RWB never reached; IF one clock after release.
REQ-038 opcode=000010 -> JMP with PCWrite=1 and PCSource=10 for one cycle; sequence totals 3 cycles.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, datapath selects.
// The control decode per state lives here so the controller only adds sequencing.
package multicycle_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_RST   = 4'd0,
        S_IF    = 4'd1,
        S_ID    = 4'd2,
        S_MADDR = 4'd3,
        S_MRD   = 4'd4,
        S_MWB   = 4'd5,
        S_MWR   = 4'd6,
        S_REXE  = 4'd7,
        S_RWB   = 4'd8,
        S_IEXE  = 4'd9,
        S_IWB   = 4'd10,
        S_BEQ   = 4'd11,
        S_JMP   = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_ADDI  = 2'b11
    } aluop_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alusrcb_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_RSVD   = 2'b11
    } pcsrc_t;

    typedef struct packed {
        logic     pc_write;
        logic     pc_write_cond;
        pcsrc_t   pc_source;
        logic     iord;
        logic     mem_read;
        logic     mem_write;
        logic     ir_write;
        logic     reg_dst;
        logic     mem_to_reg;
        logic     reg_write;
        logic     alu_src_a;
        alusrcb_t alu_src_b;
        aluop_t   alu_op;
    } ctrl_t;

    // Moore decode: everything not set for a state stays 0.
    function automatic ctrl_t decode_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_IF: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            S_ID:    c.alu_src_b = SRCB_IMM_SH2;
            S_MADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_MWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_REXE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_IEXE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADDI;
            end
            S_IWB:   c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_ALUOUT;
            end
            S_JMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_JUMP;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/mem handshake in, control enables and debug state out.
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [OP_W-1:0]    opcode;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic [1:0]         PCSource;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegDst;
    logic               MemtoReg;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op, state
    );

endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM (lw/sw/R/addi/beq/j). Define MEM_READY_EN to stretch
// IF, MRD and MWR until mem_ready; otherwise every state lasts one cycle.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    state_t state;
    state_t state_nxt;
    logic   illegal_nxt;
    logic   illegal_op_q;
    logic   mem_go_c;
    ctrl_t  ctrl_c;

`ifdef MEM_READY_EN
    assign mem_go_c = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_go_c         = 1'b1;
`endif

    // Next-state and illegal-opcode detect
    always_comb begin
        state_nxt   = state;
        illegal_nxt = 1'b0;
        case (state)
            S_RST: state_nxt = S_IF;
            S_IF:  if (mem_go_c) state_nxt = S_ID;
            S_ID: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_nxt = S_MADDR;
                    OP_RTYPE:     state_nxt = S_REXE;
                    OP_ADDI:      state_nxt = S_IEXE;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_J:         state_nxt = S_JMP;
                    default: begin
                        state_nxt   = S_IF;
                        illegal_nxt = 1'b1;
                    end
                endcase
            end
            S_MADDR: state_nxt = (bus.opcode == OP_SW) ? S_MWR : S_MRD;
            S_MRD:   if (mem_go_c) state_nxt = S_MWB;
            S_MWR:   if (mem_go_c) state_nxt = S_IF;
            S_REXE:  state_nxt = S_RWB;
            S_IEXE:  state_nxt = S_IWB;
            default: state_nxt = S_IF;
        endcase
    end

    // PC and IR only latch on the fetch cycle that actually completes
    always_comb begin
        ctrl_c = decode_ctrl(state);
        if ((state == S_IF) && !mem_go_c) begin
            ctrl_c.pc_write = 1'b0;
            ctrl_c.ir_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_RST;
            illegal_op_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            illegal_op_q <= illegal_nxt;
        end
    end

    assign bus.PCWrite     = ctrl_c.pc_write;
    assign bus.PCWriteCond = ctrl_c.pc_write_cond;
    assign bus.PCSource    = ctrl_c.pc_source;
    assign bus.IorD        = ctrl_c.iord;
    assign bus.MemRead     = ctrl_c.mem_read;
    assign bus.MemWrite    = ctrl_c.mem_write;
    assign bus.IRWrite     = ctrl_c.ir_write;
    assign bus.RegDst      = ctrl_c.reg_dst;
    assign bus.MemtoReg    = ctrl_c.mem_to_reg;
    assign bus.RegWrite    = ctrl_c.reg_write;
    assign bus.ALUSrcA     = ctrl_c.alu_src_a;
    assign bus.ALUSrcB     = ctrl_c.alu_src_b;
    assign bus.ALUOp       = ctrl_c.alu_op;
    assign bus.illegal_op  = illegal_op_q;
    assign bus.state       = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random instruction stream against an instruction-level model of the controller.
// Honours MEM_READY_EN when defined (random wait states on IF/MRD/MWR).
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
    multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b001000 || op == 6'b000100 || op == 6'b000010;
    endfunction

    // {PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp}
    function automatic logic [15:0] observed();
        return {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp};
    endfunction

    function automatic logic [15:0] expected(input state_t s, input logic go);
        logic pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, sa;
        logic [1:0] pcs, sb, ao;
        {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, sa} = '0;
        pcs = 2'b00; sb = 2'b00; ao = 2'b00;
        case (s)
            S_IF:    begin mr = 1; irw = go; pcw = go; sb = 2'b01; end
            S_ID:    sb = 2'b11;
            S_MADDR: begin sa = 1; sb = 2'b10; end
            S_MRD:   begin mr = 1; iord = 1; end
            S_MWR:   begin mw = 1; iord = 1; end
            S_MWB:   begin rw = 1; m2r = 1; end
            S_REXE:  begin sa = 1; ao = 2'b10; end
            S_RWB:   begin rw = 1; rd = 1; end
            S_IEXE:  begin sa = 1; sb = 2'b10; ao = 2'b11; end
            S_IWB:   rw = 1;
            S_BEQ:   begin sa = 1; ao = 2'b01; pcwc = 1; pcs = 2'b01; end
            S_JMP:   begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, pcs, iord, mr, mw, irw, rd, m2r, rw, sa, sb, ao};
    endfunction

`ifdef MEM_READY_EN
    localparam bit WAITS = 1'b1;
`else
    localparam bit WAITS = 1'b0;
`endif

    state_t     exp_st;
    logic       exp_ill;
    logic [5:0] cur_op;
    state_t     seq[$];
    int         idx;
    bit         new_instr;
    bit         did_rexe_rst;

    function automatic logic [5:0] pick_op();
        case ($urandom % 8)
            0: return 6'b100011;
            1: return 6'b101011;
            2: return 6'b000000;
            3: return 6'b001000;
            4: return 6'b000100;
            5: return 6'b000010;
            6: return 6'b111111;
            default: return 6'($urandom);
        endcase
    endfunction

    task automatic check_all(input string tag, input state_t s, input logic go, input logic ill);
        check_eq({tag, "_state"}, 32'(bus.state), 32'(s));
        check_eq({tag, "_ctrl"}, 32'(observed()), 32'(expected(s, go)));
        check_eq({tag, "_illegal"}, 32'(bus.illegal_op), 32'(ill));
    endtask

    // Async reset pulse from mid-cycle: outputs must clear without waiting for a clock
    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        check_all("rst_async", S_RST, 1'b0, 1'b0);
        @(negedge clk);
        cyc++;
        check_all("rst_hold", S_RST, 1'b0, 1'b0);
        rst       = 1'b1;
        exp_st    = S_RST;
        exp_ill   = 1'b0;
        new_instr = 1'b0;
    endtask

    initial begin
        logic go;
        logic nxt_ill;
        bit   stall;
        rst           = 1'b0;
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        cur_op        = '0;
        idx           = 0;
        new_instr     = 1'b0;
        did_rexe_rst  = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset", S_RST, 1'b0, 1'b0);
        rst     = 1'b1;
        exp_st  = S_RST;
        exp_ill = 1'b0;

        for (int n = 0; n < 2000; n++) begin
            if (new_instr) begin
                cur_op     = pick_op();
                bus.opcode = cur_op;
                seq        = '{S_IF, S_ID};
                if (cur_op == 6'b100011)      begin seq.push_back(S_MADDR); seq.push_back(S_MRD); seq.push_back(S_MWB); end
                else if (cur_op == 6'b101011) begin seq.push_back(S_MADDR); seq.push_back(S_MWR); end
                else if (cur_op == 6'b000000) begin seq.push_back(S_REXE);  seq.push_back(S_RWB); end
                else if (cur_op == 6'b001000) begin seq.push_back(S_IEXE);  seq.push_back(S_IWB); end
                else if (cur_op == 6'b000100) seq.push_back(S_BEQ);
                else if (cur_op == 6'b000010) seq.push_back(S_JMP);
                idx       = 0;
                new_instr = 1'b0;
            end
            bus.mem_ready = 1'(($urandom % 3) != 0);

            if ((exp_st == S_REXE && !did_rexe_rst) ||
                (exp_st != S_RST && ($urandom % 80) == 0)) begin
                if (exp_st == S_REXE) did_rexe_rst = 1'b1;
                pulse_reset();
            end

            go = WAITS ? bus.mem_ready : 1'b1;
            #1;
            check_all("cycle", exp_st, go, exp_ill);

            stall   = (exp_st == S_IF || exp_st == S_MRD || exp_st == S_MWR) && !go;
            nxt_ill = (exp_st == S_ID) && !is_legal(cur_op);
            if (exp_st == S_RST) begin
                exp_st    = S_IF;
                new_instr = 1'b1;
            end else if (!stall) begin
                idx++;
                if (idx >= seq.size()) begin
                    exp_st    = S_IF;
                    new_instr = 1'b1;
                end else begin
                    exp_st = seq[idx];
                end
            end
            exp_ill = nxt_ill;

            @(negedge clk);
            cyc++;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
